sprite_mover: RTL and testbench

- Parametrised sprite-motion engine for the VGA game datapath.
- On each `go` it performs three steps in order: erase the sprite at its old position, advance the position by one step in the latched direction, then redraw the sprite.
- Generalises the fixed single-sprite mover: configurable screen size, sprite size and step, clamp or wrap at screen edges, and a direction latch for continuous motion.
- Drives the VGA adapter plot interface directly.

---
 rtl/sprite_mover.sv | 170 +++++++++++++++++
 tb/tb_sprite_mover.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// Sprite-motion engine: each go erases the sprite, steps it one move in the
// latched direction, then redraws it through the VGA adapter plot interface.
module sprite_mover #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPR_W    = 20,
  parameter int SPR_H    = 20,
  parameter int STEP     = 7,
  parameter int WRAP     = 0,
  parameter int INIT_X   = 70,
  parameter int INIT_Y   = 50
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           go,
  input  logic           init_load,
  input  logic [X_W-1:0] init_x,
  input  logic [Y_W-1:0] init_y,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           plot,
  output logic           colour,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [2:0]     dir,
  output logic           busy,
  output logic           done
);

  localparam int CX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPR_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPR_H - 1);

  // Bounds and step carried one bit wider than the coordinates so that
  // pos+STEP can be compared against the bound without wrapping.
  localparam logic [X_W:0] MAX_X_E  = (X_W+1)'(SCREEN_W - SPR_W);
  localparam logic [Y_W:0] MAX_Y_E  = (Y_W+1)'(SCREEN_H - SPR_H);
  localparam logic [X_W:0] STEP_X_E = (X_W+1)'(STEP);
  localparam logic [Y_W:0] STEP_Y_E = (Y_W+1)'(STEP);

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_DONE} state_t;
  typedef enum logic [2:0] {
    DIR_STOP = 3'd0, DIR_UP = 3'd1, DIR_DOWN = 3'd2, DIR_LEFT = 3'd3, DIR_RIGHT = 3'd4
  } dir_t;

  state_t          state_q, state_d;
  dir_t            dir_q, dir_d, move_dir;
  logic [X_W-1:0]  pos_x_q, pos_x_d;
  logic [Y_W-1:0]  pos_y_q, pos_y_d;
  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;

  logic [X_W:0] x_add, x_sub;
  logic [Y_W:0] y_add, y_sub;
  assign x_add = {1'b0, pos_x_q} + STEP_X_E;
  assign x_sub = {1'b0, pos_x_q} - STEP_X_E;
  assign y_add = {1'b0, pos_y_q} + STEP_Y_E;
  assign y_sub = {1'b0, pos_y_q} - STEP_Y_E;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_STOP;
      pos_x_q <= X_W'(INIT_X);
      pos_y_q <= Y_W'(INIT_Y);
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block; without it a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    move_dir = dir_q;
    case (state_q)
      S_IDLE: begin
        if (init_load) begin
          pos_x_d = ({1'b0, init_x} > MAX_X_E) ? MAX_X_E[X_W-1:0] : init_x;
          pos_y_d = ({1'b0, init_y} > MAX_Y_E) ? MAX_Y_E[Y_W-1:0] : init_y;
          dir_d   = DIR_STOP;
        end else if (go) begin
          state_d = S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        if (cx_q == CX_LAST) begin
          cx_d = '0;
          if (cy_q == CY_LAST) begin
            cy_d    = '0;
            state_d = (state_q == S_ERASE) ? S_MOVE : S_DONE;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      S_MOVE: begin
        // Buttons are active-low; none pressed keeps the latched direction.
        if      (!up)    move_dir = DIR_UP;
        else if (!down)  move_dir = DIR_DOWN;
        else if (!left)  move_dir = DIR_LEFT;
        else if (!right) move_dir = DIR_RIGHT;
        case (move_dir)
          DIR_UP:
            if (y_sub[Y_W]) begin
              pos_y_d = (WRAP != 0) ? MAX_Y_E[Y_W-1:0] : '0;
              if (WRAP == 0) move_dir = DIR_STOP;
            end else pos_y_d = y_sub[Y_W-1:0];
          DIR_DOWN:
            if (y_add > MAX_Y_E) begin
              pos_y_d = (WRAP != 0) ? '0 : MAX_Y_E[Y_W-1:0];
              if (WRAP == 0) move_dir = DIR_STOP;
            end else pos_y_d = y_add[Y_W-1:0];
          DIR_LEFT:
            if (x_sub[X_W]) begin
              pos_x_d = (WRAP != 0) ? MAX_X_E[X_W-1:0] : '0;
              if (WRAP == 0) move_dir = DIR_STOP;
            end else pos_x_d = x_sub[X_W-1:0];
          DIR_RIGHT:
            if (x_add > MAX_X_E) begin
              pos_x_d = (WRAP != 0) ? '0 : MAX_X_E[X_W-1:0];
              if (WRAP == 0) move_dir = DIR_STOP;
            end else pos_x_d = x_add[X_W-1:0];
          default: ;
        endcase
        dir_d   = move_dir;
        state_d = S_DRAW;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    plot    = (state_q == S_ERASE) || (state_q == S_DRAW);
    colour  = (state_q == S_DRAW);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    pixel_x = plot ? pos_x_q + X_W'(cx_q) : pos_x_q;
    pixel_y = plot ? pos_y_q + Y_W'(cy_q) : pos_y_q;
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: a clamp-mode and a wrap-mode instance,
// exercised one at a time through a shared output view.
module tb_sprite_mover;

  logic       clock, resetn;
  logic       go, w_go, init_load, w_init_load;
  logic [7:0] init_x;
  logic [6:0] init_y;
  logic       up, down, left, right;

  logic [7:0] pixel_x, pos_x, w_pixel_x, w_pos_x;
  logic [6:0] pixel_y, pos_y, w_pixel_y, w_pos_y;
  logic [2:0] dir, w_dir;
  logic       plot, colour, busy, done;
  logic       w_plot, w_colour, w_busy, w_done;

  bit use_wrap;
  int checks = 0;
  int errors = 0;

  sprite_mover #(.WRAP(0)) dut (
    .clock(clock), .resetn(resetn), .go(go), .init_load(init_load),
    .init_x(init_x), .init_y(init_y), .up(up), .down(down), .left(left), .right(right),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .plot(plot), .colour(colour),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .busy(busy), .done(done)
  );

  sprite_mover #(.WRAP(1)) dut_wrap (
    .clock(clock), .resetn(resetn), .go(w_go), .init_load(w_init_load),
    .init_x(init_x), .init_y(init_y), .up(up), .down(down), .left(left), .right(right),
    .pixel_x(w_pixel_x), .pixel_y(w_pixel_y), .plot(w_plot), .colour(w_colour),
    .pos_x(w_pos_x), .pos_y(w_pos_y), .dir(w_dir), .busy(w_busy), .done(w_done)
  );

  wire [7:0] m_pixel_x = use_wrap ? w_pixel_x : pixel_x;
  wire [6:0] m_pixel_y = use_wrap ? w_pixel_y : pixel_y;
  wire [7:0] m_pos_x   = use_wrap ? w_pos_x   : pos_x;
  wire [6:0] m_pos_y   = use_wrap ? w_pos_y   : pos_y;
  wire [2:0] m_dir     = use_wrap ? w_dir     : dir;
  wire       m_plot    = use_wrap ? w_plot    : plot;
  wire       m_colour  = use_wrap ? w_colour  : colour;
  wire       m_busy    = use_wrap ? w_busy    : busy;
  wire       m_done    = use_wrap ? w_done    : done;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic release_buttons();
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1;
  endtask

  task automatic load_pos(input int x, input int y);
    init_x = 8'(x);
    init_y = 7'(y);
    if (use_wrap) w_init_load = 1'b1; else init_load = 1'b1;
    tick();
    init_load = 1'b0;
    w_init_load = 1'b0;
  endtask

  // One full go: erase at (ox,oy), move to (nx,ny) with direction nd, draw.
  task automatic run_go(input string name, input int ox, input int oy,
                        input int nx, input int ny, input int nd);
    int err;
    if (use_wrap) w_go = 1'b1; else go = 1'b1;
    tick();
    go = 1'b0;
    w_go = 1'b0;
    err = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_plot !== 1'b1 || m_colour !== 1'b0 || m_busy !== 1'b1 || m_done !== 1'b0 ||
          m_pixel_x !== 8'(ox + i % 20) || m_pixel_y !== 7'(oy + i / 20)) err++;
      tick();
    end
    checks++;
    if (err != 0) begin
      errors++;
      $display("FAIL %s erase: %0d bad erase cycles, required 0", name, err);
    end
    checks++;
    if (m_plot !== 1'b0 || m_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s move_cycle: plot=%b busy=%b, required plot=0 busy=1", name, m_plot, m_busy);
    end
    tick();
    checks++;
    if (m_pos_x !== 8'(nx) || m_pos_y !== 7'(ny) || m_dir !== 3'(nd)) begin
      errors++;
      $display("FAIL %s new_pos: pos=(%0d,%0d) dir=%0d, required (%0d,%0d) dir=%0d",
               name, m_pos_x, m_pos_y, m_dir, nx, ny, nd);
    end
    err = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_plot !== 1'b1 || m_colour !== 1'b1 || m_busy !== 1'b1 || m_done !== 1'b0 ||
          m_pixel_x !== 8'(nx + i % 20) || m_pixel_y !== 7'(ny + i / 20)) err++;
      tick();
    end
    checks++;
    if (err != 0) begin
      errors++;
      $display("FAIL %s draw: %0d bad draw cycles, required 0", name, err);
    end
    checks++;
    if (m_done !== 1'b1 || m_plot !== 1'b0 || m_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b plot=%b busy=%b, required 1 0 1", name, m_done, m_plot, m_busy);
    end
    tick();
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s back_idle: done=%b busy=%b, required 0 0", name, m_done, m_busy);
    end
  endtask

  task automatic test_reset();
    int err;
    resetn = 1'b0;
    repeat (3) tick();
    checks++;
    if (pos_x !== 8'd70 || pos_y !== 7'd50 || dir !== 3'd0 || plot !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || colour !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pos=(%0d,%0d) dir=%0d plot=%b busy=%b done=%b, required (70,50) 0 0 0 0",
               pos_x, pos_y, dir, plot, busy, done);
    end
    resetn = 1'b1;
    err = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pos_x !== 8'd70 || pos_y !== 7'd50 || dir !== 3'd0 || plot !== 1'b0 || busy !== 1'b0) err++;
    end
    checks++;
    if (err != 0) begin
      errors++;
      $display("FAIL reset_hold: %0d unstable cycles, required 0", err);
    end
  endtask

  task automatic test_move_left();
    left = 1'b0;
    run_go("move_left", 70, 50, 63, 50, 3);
    release_buttons();
  endtask

  task automatic test_continuous();
    run_go("continuous", 63, 50, 56, 50, 3);
  endtask

  task automatic test_priority();
    up = 1'b0;
    right = 1'b0;
    run_go("priority", 56, 50, 56, 43, 1);
    release_buttons();
  endtask

  task automatic test_clamp();
    load_pos(200, 50);
    checks++;
    if (pos_x !== 8'd140 || pos_y !== 7'd50 || dir !== 3'd0) begin
      errors++;
      $display("FAIL init_clamp: pos=(%0d,%0d) dir=%0d, required (140,50) 0", pos_x, pos_y, dir);
    end
    load_pos(133, 50);
    right = 1'b0;
    run_go("exact_bound", 133, 50, 140, 50, 4);
    load_pos(137, 50);
    run_go("clamp_right", 137, 50, 140, 50, 0);
    release_buttons();
    run_go("clamp_stopped", 140, 50, 140, 50, 0);
  endtask

  task automatic test_wrap();
    use_wrap = 1'b1;
    load_pos(3, 50);
    left = 1'b0;
    run_go("wrap_left", 3, 50, 140, 50, 3);
    release_buttons();
    load_pos(20, 100);
    down = 1'b0;
    run_go("wrap_down", 20, 100, 20, 0, 2);
    release_buttons();
    run_go("wrap_continue", 20, 0, 20, 7, 2);
    use_wrap = 1'b0;
  endtask

  task automatic test_reset_mid_draw();
    int err;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (499) tick();
    checks++;
    if (plot !== 1'b1 || colour !== 1'b1) begin
      errors++;
      $display("FAIL mid_draw: plot=%b colour=%b at cycle 500, required 1 1", plot, colour);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pos_x !== 8'd70 || pos_y !== 7'd50 || dir !== 3'd0) begin
      errors++;
      $display("FAIL abort: plot=%b busy=%b done=%b pos=(%0d,%0d) dir=%0d, required 0 0 0 (70,50) 0",
               plot, busy, done, pos_x, pos_y, dir);
    end
    resetn = 1'b1;
    err = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) err++;
    end
    checks++;
    if (err != 0) begin
      errors++;
      $display("FAIL post_abort_quiet: %0d active cycles, required 0", err);
    end
    init_x = 8'd30;
    init_y = 7'd40;
    init_load = 1'b1;
    go = 1'b1;
    tick();
    init_load = 1'b0;
    go = 1'b0;
    err = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || plot !== 1'b0) err++;
      tick();
    end
    checks++;
    if (pos_x !== 8'd30 || pos_y !== 7'd40 || err != 0) begin
      errors++;
      $display("FAIL load_beats_go: pos=(%0d,%0d) busy_cycles=%0d, required (30,40) 0", pos_x, pos_y, err);
    end
  endtask

  initial begin
    use_wrap    = 1'b0;
    resetn      = 1'b0;
    go          = 1'b0;
    w_go        = 1'b0;
    init_load   = 1'b0;
    w_init_load = 1'b0;
    init_x      = '0;
    init_y      = '0;
    release_buttons();
    test_reset();
    test_move_left();
    test_continuous();
    test_priority();
    test_clamp();
    test_wrap();
    test_reset_mid_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
